// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
// Package     : instr_pkg
// Description : Shared instruction-word definitions: word width, MIPS-style
//               field bit positions and the packed decoded-field struct.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_pkg;

    localparam int INSTR_W  = 32;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

    // rd and funct overlap the immediate; all views are kept so any stage can
    // pick the interpretation it needs.
    typedef struct packed {
        logic [OPC_HI-OPC_LO:0]     opcode;
        logic [RS_HI-RS_LO:0]       rs;
        logic [RT_HI-RT_LO:0]       rt;
        logic [RD_HI-RD_LO:0]       rd;
        logic [IMM_HI-IMM_LO:0]     imm;
        logic [FUNCT_HI-FUNCT_LO:0] funct;
    } instr_fields_t;

endpackage
`default_nettype wire

// File: rtl/instr_field_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_field_decode
// Description : Combinational slicing of a 32-bit instruction word into its
//               fields plus sign extension of the 16-bit immediate to XLEN.
// Ports       : instr    - instruction word
//               fields   - decoded field struct
//               imm_sext - immediate sign-extended to XLEN bits (XLEN > 16)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_field_decode
    import instr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [INSTR_W-1:0] instr,
    output instr_fields_t      fields,
    output logic [XLEN-1:0]    imm_sext
);

    assign fields.opcode = instr[OPC_HI:OPC_LO];
    assign fields.rs     = instr[RS_HI:RS_LO];
    assign fields.rt     = instr[RT_HI:RT_LO];
    assign fields.rd     = instr[RD_HI:RD_LO];
    assign fields.imm    = instr[IMM_HI:IMM_LO];
    assign fields.funct  = instr[FUNCT_HI:FUNCT_LO];

    assign imm_sext = {{(XLEN-16){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};

endmodule
`default_nettype wire

// File: rtl/instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_queue
// Description : DEPTH-entry instruction FIFO between instruction memory and
//               the control unit, valid/ready on both sides, synchronous
//               flush, head entry decoded into MIPS-style fields.
// Ports       : clk, reset (async, active-low), flush
//               in_valid / in_ready / instruction   - producer side
//               out_valid / out_ready               - consumer side
//               instr_all, instr_* , imm_sext       - decoded head entry
//               count                               - occupancy 0..DEPTH
// Options     : INSTR_QUEUE_BYPASS_EN - empty-queue combinational bypass
// Revision    : 1.0 - initial release
// ============================================================================
module instr_queue
    import instr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         instruction,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         instr_all,
    output logic [5:0]                 instr_31_26,
    output logic [4:0]                 instr_25_21,
    output logic [4:0]                 instr_20_16,
    output logic [4:0]                 instr_15_11,
    output logic [15:0]                instr_15_0,
    output logic [5:0]                 instr_5_0,
    output logic [XLEN-1:0]            imm_sext,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wp;
    logic [PTR_W-1:0]   rp;
    logic [CNT_W-1:0]   cnt;

    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               wr_en;
    logic               rd_en;
    logic [INSTR_W-1:0] head_word;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_W'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    // A pop can only retire a stored entry; a bypassed word is never stored.
    assign rd_en    = pop && !empty;

`ifdef INSTR_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass    = empty && in_valid && !flush;
    assign out_valid = !empty || bypass;
    assign head_word = bypass ? instruction : (empty ? '0 : mem[rp]);
    // Word consumed straight through is not written.
    assign wr_en     = push && !(bypass && out_ready);
`else
    assign out_valid = !empty;
    assign head_word = empty ? '0 : mem[rp];
    assign wr_en     = push;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_en) wp <= wp + PTR_W'(1);
            if (rd_en) rp <= rp + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en && !flush) begin
            mem[wp] <= instruction;
        end
    end

    instr_fields_t fields;

    instr_field_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr    (head_word),
        .fields   (fields),
        .imm_sext (imm_sext)
    );

    assign instr_all   = head_word;
    assign instr_31_26 = fields.opcode;
    assign instr_25_21 = fields.rs;
    assign instr_20_16 = fields.rt;
    assign instr_15_11 = fields.rd;
    assign instr_15_0  = fields.imm;
    assign instr_5_0   = fields.funct;
    assign count       = cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_queue
// Description : Self-checking bench for instr_queue with a word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr_all;
    logic [5:0]  instr_31_26;
    logic [4:0]  instr_25_21;
    logic [4:0]  instr_20_16;
    logic [4:0]  instr_15_11;
    logic [15:0] instr_15_0;
    logic [5:0]  instr_5_0;
    logic [XLEN-1:0] imm_sext;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    int exp_count = 0;

    always #5 clk = ~clk;

    instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr_all(instr_all), .instr_31_26(instr_31_26),
        .instr_25_21(instr_25_21), .instr_20_16(instr_20_16),
        .instr_15_11(instr_15_11), .instr_15_0(instr_15_0),
        .instr_5_0(instr_5_0), .imm_sext(imm_sext), .count(count)
    );

    // Advance one clock and update the reference model from the inputs
    // that were applied in the cycle before the edge.
    task automatic tick();
        bit do_push, do_pop;
        do_push = in_valid && (exp_count != DEPTH) && !flush;
        do_pop  = out_ready && (exp_count != 0) && !flush;
`ifdef INSTR_QUEUE_BYPASS_EN
        if (exp_count == 0 && in_valid && out_ready && !flush) do_push = 1'b0;
`endif
        @(posedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(instruction);
        end
        exp_count = sb.size();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (instr_all !== 32'h0) begin errors++; $display("FAIL reset_instr_all got %h want 0", instr_all); end
        checks++; if (imm_sext !== 64'h0) begin errors++; $display("FAIL reset_imm_sext got %h want 0", imm_sext); end
    endtask

    task automatic test_decode();
        in_valid = 1'b1; out_ready = 1'b0; instruction = 32'h8C22_0004;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dec_out_valid got %b want 1", out_valid); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL dec_count got %0d want 1", count); end
        checks++; if (instr_31_26 !== 6'h23) begin errors++; $display("FAIL dec_opcode got %h want 23", instr_31_26); end
        checks++; if (instr_25_21 !== 5'd1) begin errors++; $display("FAIL dec_rs got %0d want 1", instr_25_21); end
        checks++; if (instr_20_16 !== 5'd2) begin errors++; $display("FAIL dec_rt got %0d want 2", instr_20_16); end
        checks++; if (instr_15_11 !== 5'd0) begin errors++; $display("FAIL dec_rd got %0d want 0", instr_15_11); end
        checks++; if (instr_15_0 !== 16'h0004) begin errors++; $display("FAIL dec_imm got %h want 0004", instr_15_0); end
        checks++; if (instr_5_0 !== 6'h04) begin errors++; $display("FAIL dec_funct got %h want 04", instr_5_0); end
        checks++; if (imm_sext !== 64'h0000_0000_0000_0004) begin errors++; $display("FAIL dec_sext_pos got %h want 4", imm_sext); end
        // Push and pop together with one entry: new word becomes head.
        in_valid = 1'b1; out_ready = 1'b1; instruction = 32'h2001_FFFF;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (instr_all !== sb[0]) begin errors++; $display("FAIL dec_head2 got %h want %h", instr_all, sb[0]); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL dec_count2 got %0d want 1", count); end
        checks++; if (instr_15_0 !== 16'hFFFF) begin errors++; $display("FAIL dec_imm_neg got %h want ffff", instr_15_0); end
        checks++; if (imm_sext !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL dec_sext_neg got %h want all ones", imm_sext); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dec_empty got %b want 0", out_valid); end
    endtask

    task automatic test_fill_drain(input logic [31:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; out_ready = 1'b0; instruction = base + 32'(i * 17);
            tick();
        end
        checks++; if (count !== 3'(DEPTH)) begin errors++; $display("FAIL fill_count got %0d want %0d", count, DEPTH); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        instruction = 32'hBAD0_0000 | base;
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'(DEPTH)) begin errors++; $display("FAIL fill_overflow_count got %0d want %0d", count, DEPTH); end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (instr_all !== sb[0]) begin errors++; $display("FAIL drain_head got %h want %h", instr_all, sb[0]); end
            checks++; if (instr_all !== base + 32'(i * 17)) begin errors++; $display("FAIL drain_order got %h want %h", instr_all, base + 32'(i * 17)); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %b want 0", out_valid); end
        checks++; if (instr_all !== 32'h0) begin errors++; $display("FAIL drain_zero got %h want 0", instr_all); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; out_ready = 1'b0; instruction = 32'h1000_0000 + 32'(i);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            instruction = 32'h2000_0000 + 32'(i);
            checks++; if (instr_all !== sb[0]) begin errors++; $display("FAIL b2b_head got %h want %h", instr_all, sb[0]); end
            tick();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", count); end
        end
        in_valid = 1'b0;
        while (exp_count != 0) begin
            checks++; if (instr_all !== sb[0]) begin errors++; $display("FAIL b2b_drain got %h want %h", instr_all, sb[0]); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; out_ready = 1'b0; instruction = 32'h3000_0000 + 32'(i);
            tick();
        end
        flush = 1'b1; instruction = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
        in_valid = 1'b1; instruction = 32'h0123_4567;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (instr_all !== 32'h0123_4567) begin errors++; $display("FAIL flush_next got %h want 01234567", instr_all); end
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drained got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; out_ready = 1'b0; instruction = 32'hFFFF_0000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        sb.delete(); exp_count = 0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL arst_count got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
        checks++; if (instr_all !== 32'h0 || imm_sext !== 64'h0) begin errors++; $display("FAIL arst_fields got %h/%h want 0", instr_all, imm_sext); end
        #1;
        reset = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_after got %b want 0", out_valid); end
    endtask

`ifdef INSTR_QUEUE_BYPASS_EN
    task automatic test_bypass();
        in_valid = 1'b1; out_ready = 1'b1; instruction = 32'h8C22_0004;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL byp_out_valid got %b want 1", out_valid); end
        checks++; if (instr_all !== 32'h8C22_0004) begin errors++; $display("FAIL byp_instr got %h want 8c220004", instr_all); end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL byp_count got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL byp_after got %b want 0", out_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_decode();
        test_fill_drain(32'hA000_0001);
        test_fill_drain(32'h5000_0100);
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef INSTR_QUEUE_BYPASS_EN
        test_bypass();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
